// File: rtl/alu_share_ctrl_if.sv
// Command, ALU and response bundle for alu_share_ctrl. The slave view is the
// controller; the master view is the surrounding requesters, ALU and consumer.
interface alu_share_ctrl_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [3:0] req0_a;
  logic [3:0] req0_b;
  logic [1:0] req0_op;
  logic       req1_valid;
  logic       req1_ready;
  logic [3:0] req1_a;
  logic [3:0] req1_b;
  logic [1:0] req1_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_sel;
  logic [7:0] alu_result;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_id;
  logic       rsp_err;
  logic       busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_sel,
    input  alu_result,
    output rsp_valid, rsp_data, rsp_id, rsp_err,
    input  rsp_ready,
    output busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_sel,
    output alu_result,
    input  rsp_valid, rsp_data, rsp_id, rsp_err,
    output rsp_ready,
    input  busy
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin controller sharing one registered 4-bit ALU between two requesters;
// divide-by-zero is answered locally and results return on a tagged valid/ready channel.
module alu_share_ctrl #(
  parameter int unsigned ALU_LAT = 1
) (
  input logic             clk,
  input logic             rst,
  alu_share_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state;
  logic [2:0] count;
  logic       last_grant;
  logic       grant0;
  logic       grant1;
  logic       accept;
  logic       pick;
  logic [3:0] pick_a;
  logic [3:0] pick_b;
  logic [1:0] pick_op;
  logic       div_zero;
  logic [7:0] masked;

  // Grant only in IDLE; on a tie the requester that lost last time wins
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0 = last_grant;
        grant1 = ~last_grant;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end else begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign accept   = grant0 | grant1;
  assign pick     = grant1;
  assign pick_a   = pick ? bus.req1_a  : bus.req0_a;
  assign pick_b   = pick ? bus.req1_b  : bus.req0_b;
  assign pick_op  = pick ? bus.req1_op : bus.req0_op;
  assign div_zero = (pick_op == 2'b11) && (pick_b == 4'd0);

  // The ALU only refreshes the low bits; the upper bits of alu_result are stale
  assign masked = (bus.alu_sel == 2'b11) ? {4'd0, bus.alu_result[3:0]}
                                         : {3'd0, bus.alu_result[4:0]};

  // Controller FSM: all ALU drive and response outputs are registered here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      count         <= 3'd0;
      last_grant    <= 1'b1;
      bus.alu_a     <= 4'd0;
      bus.alu_b     <= 4'd0;
      bus.alu_sel   <= 2'd0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= 8'd0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            bus.alu_a   <= pick_a;
            bus.alu_b   <= pick_b;
            bus.alu_sel <= pick_op;
            bus.rsp_id  <= pick;
            last_grant  <= pick;
            bus.busy    <= 1'b1;
            if (div_zero) begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_data  <= 8'd0;
              bus.rsp_err   <= 1'b1;
            end else begin
              state       <= WAIT;
              count       <= 3'(ALU_LAT);
              bus.rsp_err <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (count == 3'd0) begin
            bus.rsp_data  <= masked;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end else begin
            count <= count - 3'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          bus.rsp_valid <= 1'b0;
          bus.busy      <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: instance 0 uses ALU_LAT=1, instance 1 uses ALU_LAT=3.
// A transaction-level model is checked every cycle; directed literals pin the model.
module tb_alu_share_ctrl;
  logic       clk;
  logic       rst_v    [2];
  logic [1:0] rq_valid [2];
  logic [3:0] rq_a     [2][2];
  logic [3:0] rq_b     [2][2];
  logic [1:0] rq_op    [2][2];
  logic       rsp_rdy  [2];

  wire [1:0] o_ready [2];
  wire [3:0] o_alu_a [2];
  wire [3:0] o_alu_b [2];
  wire [1:0] o_sel   [2];
  wire       o_valid [2];
  wire [7:0] o_data  [2];
  wire       o_id    [2];
  wire       o_err   [2];
  wire       o_busy  [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Stand-in ALU: correct low bits, deliberately junk upper bits
  function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel);
    logic [7:0] t;
    case (sel)
      2'b00:   begin t = {4'd0, a} + {4'd0, b}; return {3'b101, t[4:0]}; end
      2'b01:   begin t = {4'd0, a} - {4'd0, b}; return {3'b110, t[4:0]}; end
      2'b10:   begin t = {4'd0, a} * {4'd0, b}; return {3'b011, t[4:0]}; end
      default: begin
        if (b == 4'd0) return 8'hFF;
        t = {4'd0, a / b};
        return {4'b1001, t[3:0]};
      end
    endcase
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_inst
    localparam int LAT = (k == 0) ? 1 : 3;
    alu_share_ctrl_if bus ();
    logic [7:0] pipe [LAT];

    assign bus.req0_valid = rq_valid[k][0];
    assign bus.req1_valid = rq_valid[k][1];
    assign bus.req0_a     = rq_a[k][0];
    assign bus.req0_b     = rq_b[k][0];
    assign bus.req0_op    = rq_op[k][0];
    assign bus.req1_a     = rq_a[k][1];
    assign bus.req1_b     = rq_b[k][1];
    assign bus.req1_op    = rq_op[k][1];
    assign bus.rsp_ready  = rsp_rdy[k];
    assign bus.alu_result = pipe[LAT-1];

    always @(posedge clk) begin
      pipe[0] <= alu_fn(bus.alu_a, bus.alu_b, bus.alu_sel);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    assign o_ready[k] = {bus.req1_ready, bus.req0_ready};
    assign o_alu_a[k] = bus.alu_a;
    assign o_alu_b[k] = bus.alu_b;
    assign o_sel[k]   = bus.alu_sel;
    assign o_valid[k] = bus.rsp_valid;
    assign o_data[k]  = bus.rsp_data;
    assign o_id[k]    = bus.rsp_id;
    assign o_err[k]   = bus.rsp_err;
    assign o_busy[k]  = bus.busy;

    alu_share_ctrl #(.ALU_LAT(LAT)) dut (
      .clk (clk),
      .rst (rst_v[k]),
      .bus (bus)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int k, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %h, expected %h", name, k, act, exp);
    end
  endtask

  // Expected {err, data} straight from the arithmetic meaning of each op
  function automatic logic [8:0] model_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    int av = int'(a);
    int bv = int'(b);
    case (op)
      2'b00:   return {1'b0, 8'((av + bv) % 32)};
      2'b01:   return {1'b0, 8'((av - bv + 32) % 32)};
      2'b10:   return {1'b0, 8'((av * bv) % 32)};
      default: begin
        if (bv == 0) return {1'b1, 8'd0};
        return {1'b0, 8'((av / bv) % 16)};
      end
    endcase
  endfunction

  // Transaction model: a pending job becomes visible a fixed number of cycles after acceptance
  bit         m_pend  [2];
  int         m_delay [2];
  bit         m_last  [2];
  logic [3:0] m_a     [2];
  logic [3:0] m_b     [2];
  logic [1:0] m_op    [2];
  logic [7:0] m_data  [2];
  logic [7:0] m_pdata [2];
  bit         m_id    [2];
  bit         m_err   [2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [1:0] er;
      logic       ev;
      logic       g0;
      logic       g1;
      logic [8:0] res;
      int         r;
      if (rst_v[k]) begin
        m_pend[k] = 1'b0; m_delay[k] = 0; m_last[k] = 1'b1;
        m_a[k] = 4'd0; m_b[k] = 4'd0; m_op[k] = 2'd0;
        m_data[k] = 8'd0; m_id[k] = 1'b0; m_err[k] = 1'b0;
      end
      ev = m_pend[k] && (m_delay[k] == 0);
      g0 = rq_valid[k][0] && (!rq_valid[k][1] || m_last[k]);
      g1 = rq_valid[k][1] && (!rq_valid[k][0] || !m_last[k]);
      er = m_pend[k] ? 2'b00 : {g1, g0};
      check("req_ready", k, 16'(o_ready[k]), 16'(er));
      check("alu_a",     k, 16'(o_alu_a[k]), 16'(m_a[k]));
      check("alu_b",     k, 16'(o_alu_b[k]), 16'(m_b[k]));
      check("alu_sel",   k, 16'(o_sel[k]),   16'(m_op[k]));
      check("rsp_valid", k, 16'(o_valid[k]), 16'(ev));
      check("rsp_data",  k, 16'(o_data[k]),  16'(m_data[k]));
      check("rsp_id",    k, 16'(o_id[k]),    16'(m_id[k]));
      check("rsp_err",   k, 16'(o_err[k]),   16'(m_err[k]));
      check("busy",      k, 16'(o_busy[k]),  16'(m_pend[k]));
      if (!rst_v[k]) begin
        if (ev && rsp_rdy[k]) begin
          m_pend[k] = 1'b0;
        end else if (er != 2'b00) begin
          r = er[1] ? 1 : 0;
          m_a[k] = rq_a[k][r]; m_b[k] = rq_b[k][r]; m_op[k] = rq_op[k][r];
          m_id[k] = r[0]; m_last[k] = r[0];
          res = model_op(rq_a[k][r], rq_b[k][r], rq_op[k][r]);
          m_err[k] = res[8];
          m_pdata[k] = res[7:0];
          m_pend[k] = 1'b1;
          if (res[8]) begin
            m_delay[k] = 0;
            m_data[k]  = 8'd0;
          end else begin
            m_delay[k] = (k == 0 ? 1 : 3) + 1;
          end
        end else if (m_pend[k] && m_delay[k] > 0) begin
          m_delay[k] = m_delay[k] - 1;
          if (m_delay[k] == 0) m_data[k] = m_pdata[k];
        end
      end
    end
  end

  task automatic timeout(input string name, input int k);
    n_tests++;
    n_fail++;
    $display("FAIL %s inst%0d: no event within 40 cycles", name, k);
  endtask

  task automatic set_req(input int k, input int r, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    rq_a[k][r] = a; rq_b[k][r] = b; rq_op[k][r] = op;
    rq_valid[k][r] = 1'b1;
  endtask

  task automatic wait_ready(input int k, input int r);
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (o_ready[k][r]) ok = 1'b1;
    end
    if (!ok) timeout("ready_wait", k);
  endtask

  task automatic wait_valid(input int k, output int cycles);
    bit ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      cycles++;
      if (o_valid[k]) ok = 1'b1;
    end
    if (!ok) timeout("valid_wait", k);
  endtask

  task automatic do_cmd(input int k, input int r, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                        input logic [7:0] xdata, input logic xerr, input int xlat, input string name);
    int cyc;
    set_req(k, r, a, b, op);
    wait_ready(k, r);
    @(posedge clk); #1;
    rq_valid[k][r] = 1'b0;
    wait_valid(k, cyc);
    check({name, "_lat"},  k, 16'(cyc),       16'(xlat));
    check({name, "_data"}, k, 16'(o_data[k]), 16'(xdata));
    check({name, "_id"},   k, 16'(o_id[k]),   16'(r));
    check({name, "_err"},  k, 16'(o_err[k]),  16'(xerr));
    check({name, "_alu"},  k, {6'd0, o_alu_a[k], o_alu_b[k], o_sel[k]}, {6'd0, a, b, op});
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset(input int k);
    rst_v[k] = 1'b1;
    rq_valid[k] = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst_v[k] = 1'b0;
  endtask

  initial begin
    int cyc;
    for (int k = 0; k < 2; k++) begin
      rst_v[k] = 1'b1; rq_valid[k] = 2'b00; rsp_rdy[k] = 1'b1;
      for (int r = 0; r < 2; r++) begin
        rq_a[k][r] = 4'd0; rq_b[k][r] = 4'd0; rq_op[k][r] = 2'd0;
      end
    end
    @(negedge clk);
    check("reset_valid", 0, 16'(o_valid[0]), 16'd0);
    check("reset_busy",  0, 16'(o_busy[0]),  16'd0);
    repeat (2) @(posedge clk);
    #1 rst_v[0] = 1'b0; rst_v[1] = 1'b0;

    // Single add, then sub wrap and mul on requester 1
    do_cmd(0, 0, 4'd3, 4'd5, 2'b00, 8'h08, 1'b0, 3, "add");
    do_cmd(0, 1, 4'd2, 4'd3, 2'b01, 8'h1F, 1'b0, 3, "sub");
    do_cmd(0, 1, 4'd7, 4'd3, 2'b10, 8'h15, 1'b0, 3, "mul");
    do_cmd(0, 0, 4'd15, 4'd15, 2'b00, 8'h1E, 1'b0, 3, "add_max");

    // Divide, then divide by zero answered without the ALU
    do_cmd(0, 0, 4'd9, 4'd2, 2'b11, 8'h04, 1'b0, 3, "div");
    do_cmd(0, 0, 4'd9, 4'd0, 2'b11, 8'h00, 1'b1, 1, "div0");

    // Contention from reset: grants alternate starting with requester 0
    pulse_reset(0);
    set_req(0, 0, 4'd4, 4'd4, 2'b00);
    set_req(0, 1, 4'd5, 4'd9, 2'b01);
    for (int i = 0; i < 6; i++) begin
      wait_valid(0, cyc);
      check("rr_id", 0, 16'(o_id[0]), 16'(i % 2));
      check("rr_data", 0, 16'(o_data[0]), (i % 2 == 0) ? 16'h0008 : 16'h001C);
      @(posedge clk); #1;
    end
    rq_valid[0] = 2'b00;
    @(posedge clk); #1;

    // Backpressure with requester 1 waiting
    rsp_rdy[0] = 1'b0;
    set_req(0, 0, 4'd1, 4'd2, 2'b00);
    wait_ready(0, 0);
    @(posedge clk); #1;
    rq_valid[0][0] = 1'b0;
    set_req(0, 1, 4'd6, 4'd6, 2'b10);
    wait_valid(0, cyc);
    check("bp_lat", 0, 16'(cyc), 16'd3);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_valid", 0, 16'(o_valid[0]), 16'd1);
      check("bp_data",  0, 16'(o_data[0]),  16'h0003);
      check("bp_id",    0, 16'(o_id[0]),    16'd0);
      check("bp_ready", 0, 16'(o_ready[0]), 16'd0);
    end
    @(posedge clk); #1;
    rsp_rdy[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_grant_after", 0, 16'(o_ready[0]), 16'b10);
    @(posedge clk); #1;
    rq_valid[0][1] = 1'b0;
    wait_valid(0, cyc);
    check("bp_next_data", 0, 16'(o_data[0]), 16'h0004);
    check("bp_next_id",   0, 16'(o_id[0]),   16'd1);
    @(posedge clk); #1;

    // Reset in the second WAIT cycle of the ALU_LAT=3 instance
    do_cmd(1, 1, 4'd2, 4'd2, 2'b00, 8'h04, 1'b0, 5, "lat3_add");
    set_req(1, 0, 4'd5, 4'd6, 2'b10);
    wait_ready(1, 0);
    @(posedge clk); #1;
    rq_valid[1][0] = 1'b0;
    @(posedge clk); #1;
    rst_v[1] = 1'b1;
    #1;
    check("rst_valid", 1, 16'(o_valid[1]), 16'd0);
    check("rst_busy",  1, 16'(o_busy[1]),  16'd0);
    check("rst_alu",   1, {6'd0, o_alu_a[1], o_alu_b[1], o_sel[1]}, 16'd0);
    check("rst_rsp",   1, {6'd0, o_data[1], o_id[1], o_err[1]}, 16'd0);
    @(posedge clk); #1;
    rst_v[1] = 1'b0;
    set_req(1, 0, 4'd1, 4'd1, 2'b00);
    set_req(1, 1, 4'd2, 4'd2, 2'b01);
    @(negedge clk);
    check("rst_first_grant", 1, 16'(o_ready[1]), 16'b01);
    @(posedge clk); #1;
    rq_valid[1] = 2'b00;
    wait_valid(1, cyc);
    check("rst_next_lat",  1, 16'(cyc),       16'd5);
    check("rst_next_data", 1, 16'(o_data[1]), 16'h0002);
    check("rst_next_id",   1, 16'(o_id[1]),   16'd0);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
